// File: rtl/vga_pixel_timing.sv
// 640x480 raster timing generator: pixel counters, sync/blank decode, frame pulse.
// Optional VGA_COORD_MASK_EN: pixelX/pixelY read -1 while blanked.
module vga_pixel_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixEn,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               startOfFrame
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(HT - 1);
  localparam logic [10:0] V_LAST = 11'(VT - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hCnt;
  logic [10:0] vCnt;
  logic [10:0] hNxt;
  logic [10:0] vNxt;
  logic        hLast;
  logic        vLast;
  logic        hsNxt;
  logic        vsNxt;
  logic        blNxt;
  logic signed [10:0] pxNxt;
  logic signed [10:0] pyNxt;

  // Decode the next position so every output lands on the same pixel.
  always_comb begin
    hLast = (hCnt == H_LAST);
    vLast = (vCnt == V_LAST);
    hNxt  = hLast ? 11'd0 : hCnt + 11'd1;
    vNxt  = vCnt;
    if (hLast) begin
      vNxt = vLast ? 11'd0 : vCnt + 11'd1;
    end
    hsNxt = !((hNxt >= HS_BEG) && (hNxt < HS_END));
    vsNxt = !((vNxt >= VS_BEG) && (vNxt < VS_END));
    blNxt = (hNxt >= H_VIS) || (vNxt >= V_VIS);
`ifdef VGA_COORD_MASK_EN
    pxNxt = blNxt ? 11'sh7FF : $signed(hNxt);
    pyNxt = blNxt ? 11'sh7FF : $signed(vNxt);
`else
    pxNxt = $signed(hNxt);
    pyNxt = $signed(vNxt);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCnt         <= '0;
      vCnt         <= '0;
      pixelX       <= '0;
      pixelY       <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      blank        <= 1'b0;
      startOfFrame <= 1'b0;
    end else begin
      startOfFrame <= pixEn & hLast & vLast;
      if (pixEn) begin
        hCnt   <= hNxt;
        vCnt   <= vNxt;
        pixelX <= pxNxt;
        pixelY <= pyNxt;
        hsync  <= hsNxt;
        vsync  <= vsNxt;
        blank  <= blNxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Bench for vga_pixel_timing: default-size and shrunken-raster instances
// checked every cycle against a linear-position model plus literal pins.
module tb_vga_pixel_timing;

  localparam int SHA = 8;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 3;
  localparam int SVA = 6;
  localparam int SVF = 1;
  localparam int SVS = 2;
  localparam int SVB = 1;

  int HA[2]   = '{640, SHA};
  int HF[2]   = '{16, SHF};
  int HS[2]   = '{96, SHS};
  int VA[2]   = '{480, SVA};
  int VF[2]   = '{10, SVF};
  int VS[2]   = '{2, SVS};
  int HTOT[2] = '{800, SHA + SHF + SHS + SHB};
  int VTOT[2] = '{525, SVA + SVF + SVS + SVB};

  logic clk;
  logic reset;
  logic pixEn;

  logic signed [10:0] px0, py0, px1, py1;
  logic hs0, vs0, bl0, sof0;
  logic hs1, vs1, bl1, sof1;

  int mpos[2] = '{0, 0};
  bit msof[2] = '{1'b0, 1'b0};

  int nchk = 0;
  int nerr = 0;

  vga_pixel_timing dut (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .pixelX(px0), .pixelY(py0),
    .hsync(hs0), .vsync(vs0), .blank(bl0),
    .startOfFrame(sof0)
  );

  vga_pixel_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .pixelX(px1), .pixelY(py1),
    .hsync(hs1), .vsync(vs1), .blank(bl1),
    .startOfFrame(sof1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mh(input int i);
    return mpos[i] % HTOT[i];
  endfunction

  function automatic int mv(input int i);
    return mpos[i] / HTOT[i];
  endfunction

  task automatic cmp(
    input int i,
    input logic [10:0] ax, input logic [10:0] ay,
    input logic ahs, input logic avs,
    input logic abl, input logic asof
  );
    int h, v;
    logic ehs, evs, ebl;
    logic [10:0] ex, ey;
    h   = mh(i);
    v   = mv(i);
    ebl = (h >= HA[i]) || (v >= VA[i]);
    ehs = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
    evs = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
`ifdef VGA_COORD_MASK_EN
    ex = ebl ? 11'h7FF : 11'(h);
    ey = ebl ? 11'h7FF : 11'(v);
`else
    ex = 11'(h);
    ey = 11'(v);
`endif
    nchk++;
    if (ax !== ex || ay !== ey || ahs !== ehs || avs !== evs ||
        abl !== ebl || asof !== msof[i]) begin
      nerr++;
      $display("FAIL model_cmp inst%0d t=%0t got x=%0d y=%0d hs=%b vs=%b bl=%b sof=%b want x=%0d y=%0d hs=%b vs=%b bl=%b sof=%b",
               i, $time, ax, ay, ahs, avs, abl, asof,
               ex, ey, ehs, evs, ebl, msof[i]);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, px0, py0, hs0, vs0, bl0, sof0);
    cmp(1, px1, py1, hs1, vs1, bl1, sof1);
  end

  task automatic lit(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit en);
    pixEn = en;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      msof[i] = 1'b0;
      if (reset) begin
        mpos[i] = 0;
      end else if (en) begin
        mpos[i] = (mpos[i] + 1) % (HTOT[i] * VTOT[i]);
        msof[i] = (mpos[i] == 0);
      end
    end
    #1;
  endtask

  task automatic pins();
    int h0, v0, h1, v1;
    h0 = mh(0);
    v0 = mv(0);
    h1 = mh(1);
    v1 = mv(1);
    if (v0 == 0) begin
      if (h0 == 655) lit("hs_before_656", int'(hs0), 1);
      if (h0 == 656) lit("hs_fall_656", int'(hs0), 0);
      if (h0 == 751) lit("hs_low_751", int'(hs0), 0);
      if (h0 == 752) lit("hs_rise_752", int'(hs0), 1);
      if (h0 == 639) lit("blank_639", int'(bl0), 0);
      if (h0 == 640) lit("blank_640", int'(bl0), 1);
    end
    if (v0 == 1 && h0 == 0) begin
      lit("wrap_x", int'(px0), 0);
      lit("wrap_y", int'(py0), 1);
    end
    if (v0 == 10 && h0 == 639) begin
      lit("vis_x_639", int'(px0), 639);
      lit("vis_y_10", int'(py0), 10);
      lit("vis_blank", int'(bl0), 0);
    end
    if (v0 == 10 && h0 == 640) begin
`ifdef VGA_COORD_MASK_EN
      lit("mask_x_640", int'(px0), -1);
      lit("mask_y_10", int'(py0), -1);
`else
      lit("raw_x_640", int'(px0), 640);
      lit("raw_y_10", int'(py0), 10);
`endif
      lit("blank_640_10", int'(bl0), 1);
    end
    if (mpos[1] == 0 && msof[1]) begin
      lit("sof_s_pulse", int'(sof1), 1);
      lit("sof_s_x", int'(px1), 0);
      lit("sof_s_y", int'(py1), 0);
    end
    if (v1 == 6 && h1 == 15) lit("vs_s_before", int'(vs1), 1);
    if (v1 == 7 && h1 == 0) lit("vs_s_fall", int'(vs1), 0);
    if (v1 == 8 && h1 == 15) lit("vs_s_low_end", int'(vs1), 0);
    if (v1 == 9 && h1 == 0) lit("vs_s_rise", int'(vs1), 1);
    if (v1 == 5 && h1 == 7) begin
      lit("s_raw_x_7", int'(px1), 7);
      lit("s_raw_y_5", int'(py1), 5);
    end
    if (v1 == 2 && h1 == 8) begin
`ifdef VGA_COORD_MASK_EN
      lit("s_mask_x", int'(px1), -1);
`else
      lit("s_raw_x_8", int'(px1), 8);
`endif
    end
  endtask

  task automatic run(input int n, input bit gate);
    for (int k = 0; k < n; k++) begin
      step(gate ? bit'(k % 2 == 0) : 1'b1);
      pins();
    end
  endtask

  task automatic reset_pins();
    lit("rst_x", int'(px0), 0);
    lit("rst_y", int'(py0), 0);
    lit("rst_hs", int'(hs0), 1);
    lit("rst_vs", int'(vs0), 1);
    lit("rst_blank", int'(bl0), 0);
    lit("rst_sof", int'(sof0), 0);
    lit("rst_s_x", int'(px1), 0);
    lit("rst_s_y", int'(py1), 0);
  endtask

  initial begin
    reset = 1'b1;
    pixEn = 1'b0;
    step(1'b0);
    step(1'b1);
    reset = 1'b0;
    reset_pins();

    run(1900, 1'b0);
    lit("pre_rst_x", int'(px0), 300);
    lit("pre_rst_y", int'(py0), 2);

    #1;
    reset = 1'b1;
    mpos[0] = 0;
    mpos[1] = 0;
    msof[0] = 1'b0;
    msof[1] = 1'b0;
    #1;
    reset_pins();
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    reset_pins();

    step(1'b1);
    lit("post_rst_x", int'(px0), 1);
    lit("post_rst_y", int'(py0), 0);
    lit("post_rst_sof", int'(sof0), 0);

    run(8639, 1'b0);
    run(800, 1'b1);

    pixEn = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
